// File: rtl/ptp_perout_ctrl_pkg.sv
// ptp_perout_ctrl_pkg
// Shared definitions for the PTP periodic-output register block:
// register byte offsets, block identification words, control bit
// positions, ToD field layout, scheduler state encoding and the
// per-word storage mask for the start/period/width register groups.
package ptp_perout_ctrl_pkg;

    localparam logic [31:0] RB_TYPE  = 32'h0000_C082;
    localparam logic [31:0] RB_VER   = 32'h0000_0100;

    localparam logic [31:0] NS_PER_S = 32'd1_000_000_000;

    // ToD layout: {sec[47:0], ns[31:0], fns[15:0]}
    localparam int TOD_NS_LSB  = 16;
    localparam int TOD_SEC_LSB = 48;

    localparam logic [5:0] OFF_TYPE = 6'h00;
    localparam logic [5:0] OFF_VER  = 6'h04;
    localparam logic [5:0] OFF_NEXT = 6'h08;
    localparam logic [5:0] OFF_CTRL = 6'h0C;

    localparam int CTRL_PULSE  = 0;
    localparam int CTRL_EN     = 8;
    localparam int CTRL_LOCKED = 16;
    localparam int CTRL_ERROR  = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FALL_CALC,
        S_WAIT
    } sched_state_t;

    // Implemented bits of each word of a ToD register group:
    // fns [15:0], ns [29:0], sec low [31:0], sec high [15:0].
    function automatic logic [31:0] word_mask(input logic [1:0] word);
        case (word)
            2'd0:    return 32'h0000_FFFF;
            2'd1:    return 32'h3FFF_FFFF;
            2'd2:    return 32'hFFFF_FFFF;
            default: return 32'h0000_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ptp_tod_add.sv
// ptp_tod_add
// Combinational 96-bit ToD adder: sum = a + b with fractional-ns carry
// into ns, ns rollover at 1e9 into seconds, seconds wrapping mod 2^48.
// Both operands must carry ns below 1e9.
// Ports: a, b (ToD operands), sum (ToD result).
module ptp_tod_add
    import ptp_perout_ctrl_pkg::*;
(
    input  logic [95:0] a,
    input  logic [95:0] b,
    output logic [95:0] sum
);

    logic [16:0] fns_sum;
    logic [32:0] ns_sum;
    logic [31:0] ns_adj;
    logic        roll;
    logic [47:0] sec_sum;

    always_comb begin
        fns_sum = {1'b0, a[15:0]} + {1'b0, b[15:0]};
        ns_sum  = {1'b0, a[TOD_NS_LSB +: 32]} + {1'b0, b[TOD_NS_LSB +: 32]}
                + {32'd0, fns_sum[16]};
        // Two sub-1e9 values plus a carry stay below 2e9, so one
        // conditional subtract is enough.
        roll    = (ns_sum >= {1'b0, NS_PER_S});
        ns_adj  = roll ? 32'(ns_sum - {1'b0, NS_PER_S}) : ns_sum[31:0];
        sec_sum = a[TOD_SEC_LSB +: 48] + b[TOD_SEC_LSB +: 48] + {47'd0, roll};
        sum     = {sec_sum, ns_adj, fns_sum[15:0]};
    end

endmodule

// File: rtl/ptp_perout_ctrl.sv
// ptp_perout_ctrl
// Register-controlled periodic pulse generator aligned to PTP ToD.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reg_wr_* / reg_rd_*      32-bit register bus (registered 1-cycle acks,
//                            read data 0 when not acknowledging)
//   ptp_ts_96, ptp_ts_step   current ToD and discontinuity strobe
//   ptp_perout_locked/error/pulse   schedule status and pulse output
module ptp_perout_ctrl
    import ptp_perout_ctrl_pkg::*;
#(
    parameter int                        REG_ADDR_WIDTH = 6,
    parameter int                        REG_DATA_WIDTH = 32,
    parameter int                        REG_STRB_WIDTH = REG_DATA_WIDTH/8,
    parameter logic [REG_ADDR_WIDTH-1:0] RB_BASE_ADDR   = '0,
    parameter logic [31:0]               RB_NEXT_PTR    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [REG_DATA_WIDTH-1:0] reg_wr_data,
    input  logic [REG_STRB_WIDTH-1:0] reg_wr_strb,
    input  logic                      reg_wr_en,
    output logic                      reg_wr_wait,
    output logic                      reg_wr_ack,
    input  logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic                      reg_rd_en,
    output logic [REG_DATA_WIDTH-1:0] reg_rd_data,
    output logic                      reg_rd_wait,
    output logic                      reg_rd_ack,
    input  logic [95:0]               ptp_ts_96,
    input  logic                      ptp_ts_step,
    output logic                      ptp_perout_locked,
    output logic                      ptp_perout_error,
    output logic                      ptp_perout_pulse
);

    // Address decode
    logic [REG_ADDR_WIDTH-1:0] wr_word, rd_word, wr_rel, rd_rel;
    logic [5:0]                wr_off, rd_off;
    logic                      wr_hit, rd_hit;

    assign wr_word = reg_wr_addr & ~(REG_ADDR_WIDTH'(3));
    assign rd_word = reg_rd_addr & ~(REG_ADDR_WIDTH'(3));
    assign wr_rel  = wr_word - RB_BASE_ADDR;
    assign rd_rel  = rd_word - RB_BASE_ADDR;
    assign wr_off  = wr_rel[5:0];
    assign rd_off  = rd_rel[5:0];
    assign wr_hit  = reg_wr_en && (wr_word >= RB_BASE_ADDR)
                  && ({1'b0, wr_rel} < (REG_ADDR_WIDTH+1)'(64));
    assign rd_hit  = reg_rd_en && (rd_word >= RB_BASE_ADDR)
                  && ({1'b0, rd_rel} < (REG_ADDR_WIDTH+1)'(64));

    logic ctrl_wr, ctrl_rd, disable_wr, commit;
    assign ctrl_wr    = wr_hit && (wr_off == OFF_CTRL);
    assign ctrl_rd    = rd_hit && (rd_off == OFF_CTRL);
    assign disable_wr = ctrl_wr && reg_wr_strb[1] && !reg_wr_data[CTRL_EN];
    // Any sec-high word (offset 0x1C/0x2C/0x3C) commits its group.
    assign commit     = wr_hit && (wr_off[5:4] != 2'd0) && (wr_off[3:2] == 2'd3);

    // Start (1), period (2) and width (3) groups: shadow words + active ToD
    logic [31:0] shadow_word [1:3];
    logic [95:0] blk_tod     [1:3];

    generate
        for (genvar gi = 1; gi <= 3; gi++) begin : g_blk
            localparam logic [31:0] RST_W1 = (gi == 3) ? 32'd1000 : 32'd0;
            localparam logic [31:0] RST_W2 = (gi == 2) ? 32'd1    : 32'd0;

            logic [31:0] sh_reg [4];
            logic [95:0] act_reg;
            logic [31:0] merged;
            logic        blk_wr;

            assign blk_wr = wr_hit && (wr_off[5:4] == 2'(gi));

            always_comb begin
                merged = sh_reg[wr_off[3:2]];
                for (int bi = 0; bi < 4; bi++) begin
                    if (reg_wr_strb[bi]) begin
                        merged[bi*8 +: 8] = reg_wr_data[bi*8 +: 8];
                    end
                end
                merged = merged & word_mask(wr_off[3:2]);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sh_reg[0] <= '0;
                    sh_reg[1] <= RST_W1;
                    sh_reg[2] <= RST_W2;
                    sh_reg[3] <= '0;
                    act_reg   <= {16'd0, RST_W2, RST_W1, 16'd0};
                end else if (blk_wr) begin
                    sh_reg[wr_off[3:2]] <= merged;
                    if (wr_off[3:2] == 2'd3) begin
                        act_reg <= {merged[15:0], sh_reg[2], sh_reg[1], sh_reg[0][15:0]};
                    end
                end
            end

            assign shadow_word[gi] = sh_reg[rd_off[3:2]];
            assign blk_tod[gi]     = act_reg;
        end
    endgenerate

    // Register interface
    logic        enable_reg, wr_ack_reg, rd_ack_reg;
    logic [31:0] rd_data_reg, rd_value;
    logic        pulse_reg, locked_reg, error_reg;

    always_comb begin
        rd_value = '0;
        case (rd_off)
            OFF_TYPE: rd_value = RB_TYPE;
            OFF_VER:  rd_value = RB_VER;
            OFF_NEXT: rd_value = RB_NEXT_PTR;
            OFF_CTRL: begin
                rd_value[CTRL_PULSE]  = pulse_reg;
                rd_value[CTRL_EN]     = enable_reg;
                rd_value[CTRL_LOCKED] = locked_reg;
                rd_value[CTRL_ERROR]  = error_reg;
            end
            default:  rd_value = shadow_word[rd_off[5:4]];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_reg  <= 1'b0;
            wr_ack_reg  <= 1'b0;
            rd_ack_reg  <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            wr_ack_reg  <= wr_hit;
            rd_ack_reg  <= rd_hit;
            rd_data_reg <= rd_hit ? rd_value : 32'd0;
            if (ctrl_wr && reg_wr_strb[1]) begin
                enable_reg <= reg_wr_data[CTRL_EN];
            end
        end
    end

    assign reg_wr_wait = 1'b0;
    assign reg_rd_wait = 1'b0;
    assign reg_wr_ack  = wr_ack_reg;
    assign reg_rd_ack  = rd_ack_reg;
    assign reg_rd_data = rd_data_reg;

    // Scheduler
    sched_state_t state_reg;
    logic [95:0]  next_rise_reg, next_fall_reg, fall_sum, rise_sum;

    ptp_tod_add u_fall_add (.a(next_rise_reg), .b(blk_tod[3]), .sum(fall_sum));
    ptp_tod_add u_rise_add (.a(next_rise_reg), .b(blk_tod[2]), .sum(rise_sum));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            next_rise_reg <= '0;
            next_fall_reg <= '0;
            pulse_reg     <= 1'b0;
            locked_reg    <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            // Clear-on-read first so that any set below overrides it.
            if (ctrl_rd) begin
                error_reg <= 1'b0;
            end
            // A pending disable write acts immediately so the pulse drops
            // on the same edge as the write acknowledge.
            if (!enable_reg || disable_wr || ptp_ts_step || commit) begin
                if (ptp_ts_step && enable_reg && locked_reg) begin
                    error_reg <= 1'b1;
                end
                state_reg  <= S_IDLE;
                pulse_reg  <= 1'b0;
                locked_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        next_rise_reg <= blk_tod[1];
                        state_reg     <= S_FALL_CALC;
                    end
                    S_FALL_CALC: begin
                        next_fall_reg <= fall_sum;
                        locked_reg    <= (next_rise_reg > ptp_ts_96);
                        state_reg     <= S_WAIT;
                    end
                    default: begin
                        if (next_rise_reg <= ptp_ts_96) begin
                            next_rise_reg <= rise_sum;
                            if (next_fall_reg > ptp_ts_96) begin
                                // Keep the pending fall time; it is
                                // recomputed from the advanced rise after
                                // the pulse ends.
                                pulse_reg  <= 1'b1;
                                locked_reg <= 1'b1;
                            end else begin
                                pulse_reg  <= 1'b0;
                                locked_reg <= 1'b0;
                                if (locked_reg) begin
                                    error_reg <= 1'b1;
                                end
                                state_reg <= S_FALL_CALC;
                            end
                        end else if (next_fall_reg <= ptp_ts_96) begin
                            pulse_reg <= 1'b0;
                            state_reg <= S_FALL_CALC;
                        end
                    end
                endcase
            end
        end
    end

    assign ptp_perout_pulse  = pulse_reg;
    assign ptp_perout_locked = locked_reg;
    assign ptp_perout_error  = error_reg;

endmodule

// File: tb/tb_ptp_perout_ctrl.sv
// tb_ptp_perout_ctrl
// Directed self-checking bench for ptp_perout_ctrl: register map and
// handshake, periodic pulse timing, catch-up, ns rollover of the fall
// time, timestamp-step error handling and shadow/commit behaviour.
module tb_ptp_perout_ctrl;

    localparam int          AW   = 8;
    localparam logic [7:0]  BASE = 8'h40;
    localparam logic [31:0] NEXT = 32'h0000_A5A0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] reg_wr_addr = '0;
    logic [31:0]   reg_wr_data = '0;
    logic [3:0]    reg_wr_strb = '0;
    logic          reg_wr_en = 1'b0;
    logic          reg_wr_wait, reg_wr_ack;
    logic [AW-1:0] reg_rd_addr = '0;
    logic          reg_rd_en = 1'b0;
    logic [31:0]   reg_rd_data;
    logic          reg_rd_wait, reg_rd_ack;
    logic [95:0]   ts = '0;
    logic          ptp_ts_step = 1'b0;
    logic          ptp_perout_locked, ptp_perout_error, ptp_perout_pulse;

    logic [95:0]   ts_seen = '0;
    logic          ts_run = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    ptp_perout_ctrl #(
        .REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(32), .REG_STRB_WIDTH(4),
        .RB_BASE_ADDR(BASE), .RB_NEXT_PTR(NEXT)
    ) dut (
        .clk(clk), .rst(rst),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
        .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
        .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
        .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack),
        .ptp_ts_96(ts), .ptp_ts_step(ptp_ts_step),
        .ptp_perout_locked(ptp_perout_locked), .ptp_perout_error(ptp_perout_error),
        .ptp_perout_pulse(ptp_perout_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] tod(input longint unsigned sec, input longint unsigned ns);
        return {sec[47:0], ns[31:0], 16'd0};
    endfunction

    function automatic logic [95:0] tod_inc(input logic [95:0] t, input logic [31:0] dns);
        logic [47:0] s;
        logic [32:0] n;
        s = t[95:48];
        n = {1'b0, t[47:16]} + {1'b0, dns};
        if (n >= 33'd1_000_000_000) begin
            n = n - 33'd1_000_000_000;
            s = s + 48'd1;
        end
        return {s, n[31:0], t[15:0]};
    endfunction

    // One clock: remember the ToD the DUT sampled, then advance it 4 ns.
    task automatic tick();
        @(posedge clk);
        ts_seen = ts;
        #1;
        if (ts_run) ts = tod_inc(ts, 32'd4);
    endtask

    task automatic do_reset();
        ts_run = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic reg_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb,
                             output logic ack1, output logic ack2);
        reg_wr_addr = BASE + off;
        reg_wr_data = data;
        reg_wr_strb = strb;
        reg_wr_en = 1'b1;
        tick();
        ack1 = reg_wr_ack;
        reg_wr_en = 1'b0;
        tick();
        ack2 = reg_wr_ack;
    endtask

    task automatic reg_read(input logic [7:0] off, output logic [31:0] data,
                            output logic ack1, output logic ack2);
        reg_rd_addr = BASE + off;
        reg_rd_en = 1'b1;
        tick();
        ack1 = reg_rd_ack;
        data = reg_rd_data;
        reg_rd_en = 1'b0;
        tick();
        ack2 = reg_rd_ack;
    endtask

    task automatic wait_pulse(input logic level, input int budget,
                              output logic found, output logic [95:0] at_ts);
        found = 1'b0;
        at_ts = '0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (ptp_perout_pulse === level) begin
                found = 1'b1;
                at_ts = ts_seen;
            end
        end
    endtask

    task automatic set_start(input longint unsigned sec, input longint unsigned ns);
        logic a1, a2;
        reg_write(8'h10, 32'd0, 4'hF, a1, a2);
        reg_write(8'h14, ns[31:0], 4'hF, a1, a2);
        reg_write(8'h18, sec[31:0], 4'hF, a1, a2);
        reg_write(8'h1C, {16'd0, sec[47:32]}, 4'hF, a1, a2);
    endtask

    task automatic check_edge(input string name, input logic found, input logic [95:0] at_ts,
                              input logic [95:0] exp);
        n_checks++;
        if (!found || at_ts !== exp) begin
            n_fail++;
            $display("FAIL %s: found=%0b ts=%h expected ts=%h", name, found, at_ts, exp);
        end else begin
            $display("edge %s at ts=%h", name, at_ts);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic a1, a2;
        logic [31:0] exp_ids [4];
        exp_ids[0] = 32'h0000_C082;
        exp_ids[1] = 32'h0000_0100;
        exp_ids[2] = NEXT;
        exp_ids[3] = 32'h0;
        do_reset();
        n_checks++;
        if ({ptp_perout_pulse, ptp_perout_locked, ptp_perout_error, reg_wr_ack, reg_rd_ack} !== 5'b0
            || reg_rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: pulse/locked/error/wack/rack=%b rd_data=%h required 00000/0",
                     {ptp_perout_pulse, ptp_perout_locked, ptp_perout_error, reg_wr_ack, reg_rd_ack},
                     reg_rd_data);
        end
        for (int i = 0; i < 4; i++) begin
            reg_read(8'(i*4), d, a1, a2);
            n_checks++;
            if (d !== exp_ids[i] || a1 !== 1'b1 || a2 !== 1'b0) begin
                n_fail++;
                $display("FAIL id_read_%0d: data=%h ack=%b%b required %h ack=10", i, d, a1, a2, exp_ids[i]);
            end else $display("read off %h = %h", i*4, d);
        end
        // Just below and just above the block
        reg_rd_addr = BASE - 8'd4; reg_rd_en = 1'b1; tick(); reg_rd_en = 1'b0;
        n_checks++;
        if (reg_rd_ack !== 1'b0 || reg_rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL read_below: ack=%b data=%h required 0/0", reg_rd_ack, reg_rd_data);
        end
        reg_rd_addr = BASE + 8'h40; reg_rd_en = 1'b1; tick(); reg_rd_en = 1'b0;
        n_checks++;
        if (reg_rd_ack !== 1'b0 || reg_rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL read_above: ack=%b data=%h required 0/0", reg_rd_ack, reg_rd_data);
        end
        reg_write(8'h10, 32'hFFFF_FFFF, 4'hF, a1, a2);
        reg_read(8'h10, d, a1, a2);
        n_checks++;
        if (d !== 32'h0000_FFFF) begin
            n_fail++;
            $display("FAIL fns_mask: data=%h required 0000ffff", d);
        end else $display("read start fns = %h", d);
        reg_wr_addr = 8'h00; reg_wr_data = 32'h100; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
        tick(); reg_wr_en = 1'b0;
        n_checks++;
        if (reg_wr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL write_outside_ack: ack=%b required 0", reg_wr_ack);
        end
    endtask

    task automatic test_periodic();
        logic a1, a2, found;
        logic [95:0] at;
        do_reset();
        ts = tod(9, 999_999_000);
        ts_run = 1'b1;
        set_start(10, 0);
        reg_write(8'h0C, 32'h100, 4'hF, a1, a2);
        n_checks++;
        if (a1 !== 1'b1 || a2 !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ack_timing: ack=%b%b required 10", a1, a2);
        end
        repeat (4) tick();
        n_checks++;
        if (ptp_perout_locked !== 1'b1 || ptp_perout_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL locked_before_rise: locked=%b pulse=%b required 1/0", ptp_perout_locked, ptp_perout_pulse);
        end
        wait_pulse(1'b1, 600, found, at);
        check_edge("rise_10s", found, at, tod(10, 0));
        wait_pulse(1'b0, 600, found, at);
        check_edge("fall_10s", found, at, tod(10, 1000));
        ts = tod(10, 999_999_000);
        wait_pulse(1'b1, 600, found, at);
        check_edge("rise_11s", found, at, tod(11, 0));
        // Disable mid-pulse: pulse must be low on the acknowledge cycle.
        reg_wr_addr = BASE + 8'h0C; reg_wr_data = 32'h0; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
        tick(); reg_wr_en = 1'b0;
        n_checks++;
        if (reg_wr_ack !== 1'b1 || ptp_perout_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_mid_pulse: ack=%b pulse=%b required 1/0", reg_wr_ack, ptp_perout_pulse);
        end
        tick();
        n_checks++;
        if (ptp_perout_locked !== 1'b0 || ptp_perout_error !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_status: locked=%b error=%b required 0/0", ptp_perout_locked, ptp_perout_error);
        end
    endtask

    task automatic test_catchup();
        logic a1, a2, found, saw_pulse;
        logic [95:0] at;
        do_reset();
        ts = tod(100, 500_000_000);
        ts_run = 1'b1;
        set_start(5, 0);
        reg_write(8'h0C, 32'h100, 4'hF, a1, a2);
        saw_pulse = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (ptp_perout_pulse !== 1'b0) saw_pulse = 1'b1;
        end
        n_checks++;
        if (saw_pulse !== 1'b0 || ptp_perout_locked !== 1'b1 || ptp_perout_error !== 1'b0) begin
            n_fail++;
            $display("FAIL catchup: pulsed=%b locked=%b error=%b required 0/1/0",
                     saw_pulse, ptp_perout_locked, ptp_perout_error);
        end else $display("catchup done, locked");
        ts = tod(100, 999_999_000);
        wait_pulse(1'b1, 600, found, at);
        check_edge("rise_101s", found, at, tod(101, 0));
    endtask

    task automatic test_rollover();
        logic a1, a2, found;
        logic [95:0] at;
        do_reset();
        ts = tod(5, 699_999_000);
        ts_run = 1'b1;
        reg_write(8'h34, 32'd600_000_000, 4'hF, a1, a2);
        reg_write(8'h38, 32'd0, 4'hF, a1, a2);
        reg_write(8'h3C, 32'd0, 4'hF, a1, a2);
        set_start(5, 700_000_000);
        reg_write(8'h0C, 32'h100, 4'hF, a1, a2);
        wait_pulse(1'b1, 600, found, at);
        check_edge("rise_5.7s", found, at, tod(5, 700_000_000));
        ts = tod(6, 299_999_000);
        wait_pulse(1'b0, 600, found, at);
        check_edge("fall_6.3s", found, at, tod(6, 300_000_000));
    endtask

    task automatic test_ts_step();
        logic a1, a2, relocked;
        logic [31:0] d;
        do_reset();
        ts = tod(9, 999_999_000);
        ts_run = 1'b1;
        set_start(10, 0);
        reg_write(8'h0C, 32'h100, 4'hF, a1, a2);
        repeat (4) tick();
        ts[95:48] = ts[95:48] + 48'd3;
        ptp_ts_step = 1'b1;
        tick();
        ptp_ts_step = 1'b0;
        n_checks++;
        if (ptp_perout_error !== 1'b1 || ptp_perout_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL step_error: error=%b locked=%b required 1/0", ptp_perout_error, ptp_perout_locked);
        end
        relocked = 1'b0;
        for (int i = 0; i < 100 && !relocked; i++) begin
            tick();
            if (ptp_perout_locked === 1'b1) relocked = 1'b1;
        end
        n_checks++;
        if (!relocked) begin
            n_fail++;
            $display("FAIL step_relock: locked=%b required 1 within 100 cycles", ptp_perout_locked);
        end
        reg_read(8'h0C, d, a1, a2);
        n_checks++;
        if (d !== 32'h0101_0100) begin
            n_fail++;
            $display("FAIL ctrl_read1: data=%h required 01010100", d);
        end else $display("read ctrl = %h", d);
        reg_read(8'h0C, d, a1, a2);
        n_checks++;
        if (d !== 32'h0001_0100) begin
            n_fail++;
            $display("FAIL ctrl_read2: data=%h required 00010100", d);
        end else $display("read ctrl = %h", d);
    endtask

    task automatic test_shadow();
        logic a1, a2, found;
        logic [31:0] d;
        logic [95:0] at;
        do_reset();
        ts = tod(9, 999_999_000);
        ts_run = 1'b1;
        set_start(10, 0);
        reg_write(8'h0C, 32'h100, 4'hF, a1, a2);
        reg_write(8'h18, 32'd20, 4'hF, a1, a2);
        reg_read(8'h18, d, a1, a2);
        n_checks++;
        if (d !== 32'd20) begin
            n_fail++;
            $display("FAIL shadow_readback: data=%h required 00000014", d);
        end
        reg_write(8'h34, 32'hFFFF_FF55, 4'b0001, a1, a2);
        reg_read(8'h34, d, a1, a2);
        n_checks++;
        if (d !== 32'h0000_0355) begin
            n_fail++;
            $display("FAIL partial_strobe: data=%h required 00000355", d);
        end else $display("read width ns = %h", d);
        wait_pulse(1'b1, 600, found, at);
        check_edge("uncommitted_rise", found, at, tod(10, 0));
        wait_pulse(1'b0, 600, found, at);
        check_edge("uncommitted_fall", found, at, tod(10, 1000));
        reg_write(8'h3C, 32'd0, 4'hF, a1, a2);
        reg_write(8'h1C, 32'd0, 4'hF, a1, a2);
        repeat (6) tick();
        n_checks++;
        if (ptp_perout_locked !== 1'b1 || ptp_perout_error !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_resync: locked=%b error=%b required 1/0", ptp_perout_locked, ptp_perout_error);
        end
        ts = tod(19, 999_999_000);
        wait_pulse(1'b1, 600, found, at);
        check_edge("committed_rise", found, at, tod(20, 0));
        wait_pulse(1'b0, 600, found, at);
        check_edge("committed_fall", found, at, tod(20, 856));
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_catchup();
        test_rollover();
        test_ts_step();
        test_shadow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ptp_perout_ctrl.md
Name: ptp_perout_ctrl

Overview:
Register-controlled periodic pulse generator driven from a 96-bit time-of-day (ToD) PTP timestamp. Software programs the start time, period and pulse width through a 32-bit register-block interface. The block then drives a pulse output aligned to PTP time, plus locked and error status. It sits behind the PTP clock block on the shared register bus; read data is OR-combined with sibling register blocks.

Parameters:
REG_ADDR_WIDTH, 6, register address width; must be at least 6.
REG_DATA_WIDTH, 32, register data width; only 32 is supported.
REG_STRB_WIDTH, REG_DATA_WIDTH/8, byte-strobe width.
RB_BASE_ADDR, 0, byte address of this 0x40-byte register block.
RB_NEXT_PTR, 0, value returned by the next-pointer register.

Ports:
clk  in  1  clock for all logic.
rst  in  1  reset, synchronous, active-high.
reg_wr_addr  in  REG_ADDR_WIDTH  write byte address.
reg_wr_data  in  32  write data.
reg_wr_strb  in  4  write byte enables.
reg_wr_en  in  1  write request.
reg_wr_wait  out  1  write wait; tied 0.
reg_wr_ack  out  1  write acknowledge.
reg_rd_addr  in  REG_ADDR_WIDTH  read byte address.
reg_rd_en  in  1  read request.
reg_rd_data  out  32  read data; 0 when not selected.
reg_rd_wait  out  1  read wait; tied 0.
reg_rd_ack  out  1  read acknowledge.
ptp_ts_96  in  96  ToD timestamp: [95:48] seconds, [47:16] ns (always below 1e9), [15:0] fractional ns.
ptp_ts_step  in  1  timestamp discontinuity strobe.
ptp_perout_locked  out  1  schedule is ahead of current time.
ptp_perout_error  out  1  sticky error flag.
ptp_perout_pulse  out  1  periodic output.

Behaviour:
- Address decode: word address = addr with bits [1:0] cleared. Selected when base <= address < base+0x40. Unselected: no ack, rd_data 0.
- Handshake: ack is a registered one-cycle pulse, asserted the cycle after en when selected. rd_data is registered and valid with ack. Writes honour strobes per byte.
- Register map (offset from base):
  - 0x00: type 0x0000C082, read-only.
  - 0x04: version 0x00000100, read-only.
  - 0x08: RB_NEXT_PTR, read-only.
  - 0x0C: control. Bit 0 pulse (RO), bit 8 enable (RW), bit 16 locked (RO), bit 24 error (RO). Reading 0x0C clears error.
  - 0x10/14/18/1C: start fns [15:0], ns [29:0], sec low, sec high [15:0].
  - 0x20–0x2C: period, same four-word layout.
  - 0x30–0x3C: width, same four-word layout.
- Fractional-ns registers hold their value in [15:0]; bits [31:16] read 0.
- Start, period and width each have a shadow copy. Writes to the lower three words update only the shadow. A write to a sec-high word commits that whole shadow to the active value and forces re-sync.
- Reset values:
  - enable 0, start 0, period 1 s, width 1000 ns.
  - pulse 0, locked 0, error 0, acks 0, rd_data 0.
- Time add (A+B, both ToD):
  - fns adds with carry into ns.
  - If ns >= 1e9, subtract 1e9 and carry into seconds.
  - Seconds wrap modulo 2^48.
  - Inputs must have ns below 1e9; this is software's responsibility.
  - The add may be pipelined over 2 cycles.
- Scheduler states:
  - IDLE: entered on reset, on enable=0, on ptp_ts_step, or on commit. Outputs pulse=0, locked=0; load next_rise=start, go to FALL_CALC.
  - FALL_CALC: next_fall = next_rise + width; go to WAIT.
  - WAIT, next_rise <= ts: if next_fall > ts, set pulse=1 and locked=1. Otherwise (edge missed) set locked=0 and keep pulse=0; if locked was 1, set error. Then next_rise += period, go to FALL_CALC.
  - WAIT, next_fall <= ts (and next_rise > ts): pulse=0.
  - WAIT, otherwise: hold. locked=1 whenever next_rise > ts after a recalculation.
- Catch-up: a start time in the past advances one period per recalculation, without pulsing, until next_rise > ts.
- Error sources:
  - ptp_ts_step while enabled and locked.
  - A missed edge while locked.
- Simultaneous error set and control read: set wins.
- Writing enable=0 mid-pulse drops pulse to 0 within 1 cycle.

Decomposition:
- Shared package: register offsets, type/version IDs, the 1e9 constant, and the ToD field bit positions.
- One sub-module, ptp_tod_add: the 96-bit ToD adder with ns rollover, instantiated for next_fall and for next_rise advance (or time-multiplexed).

Test Plan:
- Reset, then read offsets 0x00/0x04/0x08/0x0C -> 0x0000C082 / 0x00000100 / RB_NEXT_PTR / 0; each ack is a 1-cycle pulse exactly 1 cycle after en; rd_data 0 for an address outside the block.
- Start = 10 s, period = 1 s, width = 1000 ns, enable; ToD advancing 4 ns/cycle from 9.999999000 s -> pulse rises when ts >= 10.000000000 s, falls at 10.000001000 s, repeats at 11 s; locked=1 before the first rise.
- Start = 5 s, ts = 100.5 s, enable -> no pulse during catch-up; locked=1; next rise at 101.0 s.
- Width 0.6 s, start ns 0.7e9 -> next_fall = start sec+1, ns 0.3e9 (ns rollover check).
- While locked, pulse ptp_ts_step and jump ts by +3 s -> error=1 and locked=0, then re-lock; reading 0x0C returns bit 24 set, a second read returns 0.
- Write start sec-low only -> schedule unchanged; then write sec-high -> commit and re-sync. Partial-strobe write of width ns byte 0 alters only bits [7:0].
